// File: rtl/siso_pkg.sv
// Shared definitions for the SISO sequencer and the SISO chain it drives.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SISO_WIDTH = 8;
    localparam int SISO_DEPTH = 8;

    // Counter must hold the larger of the two phase lengths.
    function automatic int cnt_width(input int width, input int flush);
        int max_len;
        max_len = (width > flush) ? width : flush;
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/siso_bit_counter.sv
// Loadable down-counter with a terminal-count flag (count == 1), shared by the
// SHIFT and FLUSH phases of the sequencer.
module siso_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec) begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == CNT_W'(1'b1));

endmodule

// File: rtl/siso_seq_ctrl.sv
// Serialises a parallel word LSB-first into a SISO chain, then flushes the
// chain with zeros and pulses completion.
module siso_seq_ctrl
    import siso_pkg::*;
#(
    parameter  int WIDTH = SISO_WIDTH,
    parameter  int FLUSH = SISO_DEPTH,
    localparam int CNT_W = cnt_width(WIDTH, FLUSH)
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             o_ready,
    output logic             o_ser,
    output logic             o_shift_en,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_bit_cnt
);

    // The FLUSH parameter shadows the enum literal, so states are package-qualified.
    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shreg_r;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic [CNT_W-1:0] cnt_s;
    logic             cnt_tc_s;

    siso_bit_counter #(
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .load    (cnt_load_s),
        .load_val(cnt_load_val_s),
        .dec     (cnt_dec_s),
        .cnt     (cnt_s),
        .tc      (cnt_tc_s)
    );

    // State register.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r <= siso_pkg::IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            siso_pkg::IDLE: begin
                if (in_valid) state_s = siso_pkg::SHIFT;
                else          state_s = siso_pkg::IDLE;
            end
            siso_pkg::SHIFT: begin
                if (cnt_tc_s) begin
                    if (FLUSH > 0) state_s = siso_pkg::FLUSH;
                    else           state_s = siso_pkg::DONE;
                end else begin
                    state_s = siso_pkg::SHIFT;
                end
            end
            siso_pkg::FLUSH: begin
                if (cnt_tc_s) state_s = siso_pkg::DONE;
                else          state_s = siso_pkg::FLUSH;
            end
            siso_pkg::DONE:  state_s = siso_pkg::IDLE;
            default:         state_s = siso_pkg::IDLE;
        endcase
    end

    // Counter control: load the phase length on entry, otherwise count down.
    always_comb begin
        cnt_load_s     = 1'b0;
        cnt_dec_s      = 1'b0;
        cnt_load_val_s = '0;
        case (state_r)
            siso_pkg::IDLE: begin
                if (in_valid) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = CNT_W'(WIDTH);
                end else begin
                    cnt_load_s     = 1'b0;
                end
            end
            siso_pkg::SHIFT: begin
                if (cnt_tc_s && (FLUSH > 0)) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = CNT_W'(FLUSH);
                end else begin
                    cnt_dec_s      = 1'b1;
                end
            end
            siso_pkg::FLUSH: cnt_dec_s = 1'b1;
            siso_pkg::DONE:  cnt_dec_s = 1'b0;
            default:         cnt_dec_s = 1'b0;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        o_ready    = 1'b0;
        o_ser      = 1'b0;
        o_shift_en = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_bit_cnt  = '0;
        case (state_r)
            siso_pkg::IDLE:  o_ready = 1'b1;
            siso_pkg::SHIFT: begin
                o_ser      = shreg_r[0];
                o_shift_en = 1'b1;
                o_busy     = 1'b1;
                o_bit_cnt  = cnt_s;
            end
            siso_pkg::FLUSH: begin
                o_shift_en = 1'b1;
                o_busy     = 1'b1;
                o_bit_cnt  = cnt_s;
            end
            siso_pkg::DONE: begin
                o_busy     = 1'b1;
                o_done     = 1'b1;
            end
            default:         o_ready = 1'b0;
        endcase
    end

    // Shift register: capture on accept, shift right with zero fill in SHIFT.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            shreg_r <= '0;
        end else if ((state_r == siso_pkg::IDLE) && in_valid) begin
            shreg_r <= in_data;
        end else if (state_r == siso_pkg::SHIFT) begin
            shreg_r <= shreg_r >> 1;
        end else begin
            shreg_r <= shreg_r;
        end
    end

endmodule
